reg_file_gen2: RTL and testbench
================================

Name: reg_file_gen2

Overview:
- Parametrised successor to the 8-bit general/temp register file.
- N registers of WIDTH bits, each with a per-register enable and a shared funsel op (clear/load/dec/inc).
- Two combinational read ports, lane-granular loads (byte-wise, as the IR load does), wrap or saturate arithmetic, and a sequenced clear-all engine with a busy/done handshake.
- Sits between the MUXA source and ALU/MUXC in the datapath.

Parameters:
- WIDTH, 16, register width in bits; must be a multiple of LANE_W.
- NUM_REGS, 8, number of registers; must be ≥ 2.
- LANE_W, 8, load lane width; LANE_W == WIDTH disables lane loads.
- SAT_EN, 0, 0 = inc/dec wrap; 1 = inc/dec saturate.
- BYPASS, 1, 1 = read ports forward same-cycle load data.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  NUM_REGS  per-register write enable; bit i selects register i; multiple bits allowed
- funsel  in  2  00 clear, 01 load, 10 decrement, 11 increment
- load  in  WIDTH  load data
- lane_en  in  1  0 = full-width load; 1 = single-lane load
- lane_sel  in  max(1,$clog2(WIDTH/LANE_W))  lane index for lane loads
- o1sel  in  $clog2(NUM_REGS)  read port 1 select
- o2sel  in  $clog2(NUM_REGS)  read port 2 select
- o1  out  WIDTH  read port 1 data
- o2  out  WIDTH  read port 2 data
- ovf  out  1  registered pulse: an inc/dec hit the boundary last cycle
- clr_req  in  1  request clear-all sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes

Behaviour:
- Reset (rst_n = 0 at clk edge):
  - All registers to 0, ovf = 0, clr_busy = 0, clr_done = 0, FSM to IDLE.
  - Reset overrides every other input, including mid-sweep.
- Write ops: all applied at the clk edge to every register whose enable bit is set; registers with enable = 0 hold.
  - 00: register ← 0.
  - 01, lane_en = 0: register ← load.
  - 01, lane_en = 1:
    - Bits [lane_sel*LANE_W +: LANE_W] ← load[LANE_W-1:0]; all other bits hold.
    - lane_sel ≥ WIDTH/LANE_W: no change.
  - 11: increment.
    - At all-ones: SAT_EN = 0 wraps to 0; SAT_EN = 1 holds all-ones.
  - 10: decrement.
    - At 0: SAT_EN = 0 wraps to all-ones; SAT_EN = 1 holds 0.
- ovf:
  - Next cycle = 1 if any enabled register performed inc at all-ones or dec at 0 (in either SAT mode); else 0.
  - Forced 0 during the sweep.
- Reads:
  - o1 = reg[o1sel], o2 = reg[o2sel], combinational.
  - When BYPASS = 1, funsel = 01, enable[sel] = 1 and FSM is IDLE: the port shows the post-load value (lane-merged) in the same cycle.
  - No bypass for clear/inc/dec.
  - Select ≥ NUM_REGS reads 0.
- Clear-all FSM, states IDLE, SWEEP, DONE:
  - IDLE: clr_req = 1 → SWEEP with idx = 0.
  - SWEEP: reg[idx] ← 0 each cycle, then idx++. After idx = NUM_REGS-1 → DONE.
  - DONE: clr_done = 1 for one cycle → IDLE.
  - clr_busy = 1 in SWEEP and DONE.
  - Sweep length: NUM_REGS cycles busy in SWEEP, plus 1 cycle in DONE.
- During SWEEP and DONE:
  - All user writes are ignored (enable masked).
  - Reads remain valid and show partially cleared contents.
  - clr_req is ignored.
- clr_req and a user write in the same IDLE cycle: the user write is applied on that edge; the sweep begins next cycle.
- clr_req held high after DONE starts a new sweep on the following IDLE cycle.

Decomposition:
- Shared package holds:
  - funsel encodings FS_CLR, FS_LOAD, FS_DEC, FS_INC
  - clear-FSM state enum (IDLE, SWEEP, DONE)
- One natural sub-module, reg_cell: a single register with funsel, lane merge, saturation and a boundary-hit output.
  - Instantiated NUM_REGS times via generate.
  - Top level holds the FSM, write masking, read muxes and bypass.

Test Plan:
- Reset, then defaults: after reset, o1/o2 read 0 for every select; ovf = 0, clr_busy = 0.
- Full-width load and bypass: enable = 8'h04, funsel = 01, load = 16'hBEEF, o1sel = 2 → o1 = BEEF in the same cycle; reg2 = BEEF after the edge; other registers still 0.
- Lane load: reg3 = 16'h1234; lane_en = 1, lane_sel = 1, load = 16'h00AB → reg3 = 16'hAB34.
- Wrap (SAT_EN = 0): reg0 = FFFF, funsel = 11 → reg0 = 0000, ovf = 1 next cycle. Dec from 0 → FFFF, ovf = 1.
- Saturate (SAT_EN = 1): inc of FFFF stays FFFF with ovf = 1; dec of 0 stays 0.
- Clear sweep: all registers preloaded to 5555.
  - Pulse clr_req → clr_busy high for NUM_REGS+1 cycles, reg[i] = 0 from cycle i+1, and clr_done pulses once.
  - A load with enable = FF mid-sweep is ignored.
  - rst_n low mid-sweep → FSM IDLE and all registers 0 on the next edge.

Source files
------------

// File: rtl/reg_file_gen2_pkg.sv
// Shared encodings for the gen2 register file: funsel ops and clear-all FSM states.
package reg_file_gen2_pkg;

    typedef enum logic [1:0] {
        FS_CLR  = 2'b00,
        FS_LOAD = 2'b01,
        FS_DEC  = 2'b10,
        FS_INC  = 2'b11
    } funsel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DONE  = 2'b10
    } clr_state_e;

endpackage

// File: rtl/reg_file_gen2_cell.sv
// One register: clear/load/dec/inc with lane merge, optional saturation and boundary-hit flag.
// Update on the clk edge when en is set; clr (sweep) forces zero regardless of funsel.
module reg_cell
    import reg_file_gen2_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LANE_W     = 8,
    parameter int SAT_EN     = 0,
    parameter int LANE_SEL_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [1:0]            funsel,
    input  logic [WIDTH-1:0]      load,
    input  logic                  lane_en,
    input  logic [LANE_SEL_W-1:0] lane_sel,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      load_val,
    output logic                  hit
);

    localparam int NLANES = WIDTH / LANE_W;

    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] nxt;
    logic             at_max;
    logic             at_min;
    logic             raw_hit;

    // An out-of-range lane index matches no lane, so the register holds.
    always_comb begin
        merged = q;
        for (int l = 0; l < NLANES; l++) begin
            if (lane_sel == LANE_SEL_W'(l)) begin
                merged[l*LANE_W +: LANE_W] = load[LANE_W-1:0];
            end
        end
    end

    assign load_val = lane_en ? merged : load;
    assign at_max   = &q;
    assign at_min   = ~|q;

    always_comb begin
        nxt     = q;
        raw_hit = 1'b0;
        case (funsel_e'(funsel))
            FS_CLR:  nxt = '0;
            FS_LOAD: nxt = load_val;
            FS_DEC: begin
                raw_hit = at_min;
                nxt     = (at_min && SAT_EN != 0) ? q : q - WIDTH'(1);
            end
            FS_INC: begin
                raw_hit = at_max;
                nxt     = (at_max && SAT_EN != 0) ? q : q + WIDTH'(1);
            end
            default: nxt = q;
        endcase
    end

    assign hit = en & raw_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/reg_file_gen2.sv
// N x WIDTH register file with two combinational read ports, lane loads and a clear-all sweep.
// Writes land on the clk edge; while the sweep runs (clr_busy) all user writes are dropped.
module reg_file_gen2
    import reg_file_gen2_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int LANE_W   = 8,
    parameter int SAT_EN   = 0,
    parameter int BYPASS   = 1,
    localparam int NLANES     = WIDTH / LANE_W,
    localparam int LANE_SEL_W = (NLANES > 1) ? $clog2(NLANES) : 1,
    localparam int SEL_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REGS-1:0]   enable,
    input  logic [1:0]            funsel,
    input  logic [WIDTH-1:0]      load,
    input  logic                  lane_en,
    input  logic [LANE_SEL_W-1:0] lane_sel,
    input  logic [SEL_W-1:0]      o1sel,
    input  logic [SEL_W-1:0]      o2sel,
    output logic [WIDTH-1:0]      o1,
    output logic [WIDTH-1:0]      o2,
    output logic                  ovf,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    clr_state_e           state;
    logic [SEL_W-1:0]     idx;
    logic                 idle;
    logic [NUM_REGS-1:0]  wr_en;
    logic [NUM_REGS-1:0]  sweep_clr;
    logic [NUM_REGS-1:0]  hit;
    logic [NUM_REGS-1:0]  byp;
    logic [WIDTH-1:0]     q        [NUM_REGS];
    logic [WIDTH-1:0]     load_val [NUM_REGS];

    assign idle  = (state == IDLE);
    assign wr_en = idle ? enable : '0;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            sweep_clr[i] = (state == SWEEP) && (idx == SEL_W'(i));
            byp[i]       = (BYPASS != 0) && idle && (funsel == FS_LOAD) && enable[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        reg_cell #(
            .WIDTH      (WIDTH),
            .LANE_W     (LANE_W),
            .SAT_EN     (SAT_EN),
            .LANE_SEL_W (LANE_SEL_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (wr_en[g]),
            .clr      (sweep_clr[g]),
            .funsel   (funsel),
            .load     (load),
            .lane_en  (lane_en),
            .lane_sel (lane_sel),
            .q        (q[g]),
            .load_val (load_val[g]),
            .hit      (hit[g])
        );
    end

    // Bypass forwards only loads; selects past NUM_REGS fall through to zero.
    always_comb begin
        o1 = '0;
        o2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (o1sel == SEL_W'(i)) o1 = byp[i] ? load_val[i] : q[i];
            if (o2sel == SEL_W'(i)) o2 = byp[i] ? load_val[i] : q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= idle & (|hit);
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= SWEEP;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (idx == SEL_W'(NUM_REGS - 1)) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_gen2.sv
// Directed bench: a wrapping and a saturating instance driven in lockstep from shared inputs.
`timescale 1ns/100ps
module tb_reg_file_gen2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  enable;
    logic [1:0]  funsel;
    logic [15:0] load;
    logic        lane_en;
    logic [0:0]  lane_sel;
    logic [2:0]  o1sel, o2sel;
    logic        clr_req;

    logic [15:0] a_o1, a_o2, b_o1, b_o2;
    logic        a_ovf, a_busy, a_done, b_ovf, b_busy, b_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    reg_file_gen2 #(.SAT_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .funsel(funsel), .load(load),
        .lane_en(lane_en), .lane_sel(lane_sel), .o1sel(o1sel), .o2sel(o2sel),
        .o1(a_o1), .o2(a_o2), .ovf(a_ovf), .clr_req(clr_req),
        .clr_busy(a_busy), .clr_done(a_done)
    );

    reg_file_gen2 #(.SAT_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .funsel(funsel), .load(load),
        .lane_en(lane_en), .lane_sel(lane_sel), .o1sel(o1sel), .o2sel(o2sel),
        .o1(b_o1), .o2(b_o2), .ovf(b_ovf), .clr_req(clr_req),
        .clr_busy(b_busy), .clr_done(b_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read register r on port 1 of both instances.
    task automatic rd(input int r, input logic [15:0] ea, input logic [15:0] eb, input string tag);
        o1sel = 3'(r);
        #0.5;
        chk($sformatf("%s_a_r%0d", tag, r), a_o1, ea);
        chk($sformatf("%s_b_r%0d", tag, r), b_o1, eb);
    endtask

    task automatic idle_inputs();
        enable  = 8'h00;
        funsel  = 2'b01;
        lane_en = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 8'hFF; funsel = 2'b11; load = 16'h0000;
        lane_en = 1'b0; lane_sel = 1'b0; o1sel = 3'd0; o2sel = 3'd0; clr_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        idle_inputs();

        // Reset defaults
        for (int r = 0; r < 8; r++) rd(r, 16'h0000, 16'h0000, "rst");
        chk("rst_ovf", 16'(a_ovf), 16'h0);
        chk("rst_busy", 16'(a_busy), 16'h0);
        chk("rst_done", 16'(a_done), 16'h0);

        // Full-width load with same-cycle bypass on o1, none on unenabled o2
        enable = 8'h04; funsel = 2'b01; load = 16'hBEEF; o2sel = 3'd3;
        rd(2, 16'hBEEF, 16'hBEEF, "byp");
        chk("byp_o2_r3", a_o2, 16'h0000);
        step();
        idle_inputs();
        rd(2, 16'hBEEF, 16'hBEEF, "load");
        rd(1, 16'h0000, 16'h0000, "load");
        rd(3, 16'h0000, 16'h0000, "load");

        // Lane loads on reg3
        enable = 8'h08; load = 16'h1234;
        step();
        lane_en = 1'b1; lane_sel = 1'b1; load = 16'h00AB;
        rd(3, 16'hAB34, 16'hAB34, "lane_byp");
        step();
        lane_en = 1'b0; enable = 8'h00;
        rd(3, 16'hAB34, 16'hAB34, "lane_hi");
        enable = 8'h08; lane_en = 1'b1; lane_sel = 1'b0; load = 16'h00CD;
        step();
        idle_inputs();
        rd(3, 16'hABCD, 16'hABCD, "lane_lo");

        // Increment at all-ones: wrap vs saturate, both flag ovf; no bypass for inc
        enable = 8'h01; load = 16'hFFFF;
        step();
        funsel = 2'b11;
        rd(0, 16'hFFFF, 16'hFFFF, "inc_nobyp");
        step();
        idle_inputs();
        rd(0, 16'h0000, 16'hFFFF, "inc_max");
        chk("inc_ovf_a", 16'(a_ovf), 16'h1);
        chk("inc_ovf_b", 16'(b_ovf), 16'h1);

        // Ordinary increment of reg2 leaves ovf low
        enable = 8'h04; funsel = 2'b11;
        step();
        idle_inputs();
        rd(2, 16'hBEF0, 16'hBEF0, "inc");
        chk("inc_noovf", 16'(a_ovf), 16'h0);

        // Clear reg0, then decrement at zero
        enable = 8'h01; funsel = 2'b00;
        step();
        idle_inputs();
        rd(0, 16'h0000, 16'h0000, "clr");
        chk("clr_ovf", 16'(b_ovf), 16'h0);
        enable = 8'h01; funsel = 2'b10;
        step();
        idle_inputs();
        rd(0, 16'hFFFF, 16'h0000, "dec_min");
        chk("dec_ovf_a", 16'(a_ovf), 16'h1);
        chk("dec_ovf_b", 16'(b_ovf), 16'h1);
        step();
        chk("ovf_drop", 16'(a_ovf), 16'h0);

        // Clear sweep; a user write in the request cycle still lands
        enable = 8'hFF; funsel = 2'b01; load = 16'h5555;
        step();
        enable = 8'h02; load = 16'h1111; clr_req = 1'b1;
        step();
        idle_inputs();
        chk("sw_busy0", 16'(a_busy), 16'h1);
        chk("sw_done0", 16'(a_done), 16'h0);
        rd(1, 16'h1111, 16'h1111, "sw_coinc");
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                enable = 8'hFF; funsel = 2'b01; load = 16'hAAAA;
                rd(7, 16'h5555, 16'h5555, "sw_nobyp");
            end
            step();
            idle_inputs();
            chk($sformatf("sw_busy_k%0d", k), 16'(a_busy), 16'h1);
            chk($sformatf("sw_done_k%0d", k), 16'(a_done), (k == 8) ? 16'h1 : 16'h0);
            chk($sformatf("sw_ovf_k%0d", k), 16'(a_ovf), 16'h0);
            rd(k - 1, 16'h0000, 16'h0000, "sw_clr");
            if (k < 8) rd(k, (k == 1) ? 16'h1111 : 16'h5555, (k == 1) ? 16'h1111 : 16'h5555, "sw_keep");
        end
        step();
        chk("sw_busy_end", 16'(a_busy), 16'h0);
        chk("sw_done_end", 16'(a_done), 16'h0);
        for (int r = 0; r < 8; r++) rd(r, 16'h0000, 16'h0000, "sw_after");

        // Reset in the middle of a sweep
        enable = 8'hFF; funsel = 2'b01; load = 16'h5555;
        step();
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        step();
        chk("mid_busy", 16'(b_busy), 16'h1);
        rd(7, 16'h5555, 16'h5555, "mid_pre");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", 16'(a_busy), 16'h0);
        chk("mid_rst_done", 16'(a_done), 16'h0);
        for (int r = 0; r < 8; r++) rd(r, 16'h0000, 16'h0000, "mid_rst");
        step();
        chk("mid_idle", 16'(b_busy), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
